// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared ROM/RAM/IO bus.
// It decodes the region, counts per-region wait states and returns a one-cycle ack.
module mem_bus_arbiter #(
  parameter int ROM_WAIT = 0,
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic        rom_nce,
  output logic        ram_nce,
  output logic        io_nce,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        cur_we;
  logic [3:0]  cnt;

  logic        pick;
  logic        pick_we;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;
  logic [2:0]  pick_region;
  logic        pick_ok;
  logic [3:0]  pick_wait;

  // Candidate grant and its region decode; only consumed while IDLE.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1)
      pick = ~last_grant;
    else if (req1)
      pick = 1'b1;
    pick_we     = pick ? we1 : we0;
    pick_addr   = pick ? addr1 : addr0;
    pick_wdata  = pick ? wdata1 : wdata0;
    pick_region = pick_addr[15:13];
    pick_ok     = 1'b0;
    pick_wait   = 4'd0;
    case (pick_region)
      3'd0: begin
        pick_ok   = ~pick_we;
        pick_wait = 4'(ROM_WAIT);
      end
      3'd1: begin
        pick_ok   = 1'b1;
        pick_wait = 4'(RAM_WAIT);
      end
      3'd2: begin
        pick_ok   = pick_we;
        pick_wait = 4'(IO_WAIT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cur_we     <= 1'b0;
      cnt        <= 4'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 32'd0;
      rdata1     <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      rom_nce    <= 1'b1;
      ram_nce    <= 1'b1;
      io_nce     <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= pick;
            last_grant <= pick;
            mem_addr   <= pick_addr;
            mem_wdata  <= pick_wdata;
            cur_we     <= pick_we;
            if (pick_ok) begin
              state   <= ACCESS;
              cnt     <= pick_wait;
              mem_re  <= ~pick_we;
              mem_we  <= pick_we;
              rom_nce <= (pick_region != 3'd0);
              ram_nce <= (pick_region != 3'd1);
              io_nce  <= (pick_region != 3'd2);
            end else begin
              // Illegal access: no bus cycle, acknowledge with error straight away.
              state <= DONE;
              if (pick) begin
                ack1 <= 1'b1;
                err1 <= 1'b1;
                if (!pick_we) rdata1 <= 32'd0;
              end else begin
                ack0 <= 1'b1;
                err0 <= 1'b1;
                if (!pick_we) rdata0 <= 32'd0;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            rom_nce <= 1'b1;
            ram_nce <= 1'b1;
            io_nce  <= 1'b1;
            if (grant) begin
              ack1 <= 1'b1;
              if (!cur_we) rdata1 <= mem_rdata;
            end else begin
              ack0 <= 1'b1;
              if (!cur_we) rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// single transactions checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int ROM_W = 0;
  localparam int RAM_W = 1;
  localparam int IO_W  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic        mem_re, mem_we, rom_nce, ram_nce, io_nce, busy;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_rd [2];

  mem_bus_arbiter #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .rom_nce(rom_nce), .ram_nce(ram_nce), .io_nce(io_nce),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference rules: which accesses are legal and how many wait states they take.
  function automatic bit is_legal(input logic we, input logic [31:0] addr);
    logic [2:0] r;
    r = addr[15:13];
    return (r == 3'd0 && !we) || (r == 3'd1) || (r == 3'd2 && we);
  endfunction

  function automatic int region_wait(input logic [31:0] addr);
    case (addr[15:13])
      3'd0:    return ROM_W;
      3'd1:    return RAM_W;
      3'd2:    return IO_W;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req0 = 0; req1 = 0; rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  // Runs one uncontended transaction and gathers observations; callers judge them.
  task automatic drive_txn(input bit who, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] bus,
                           output int lat, output int rom_c, output int ram_c, output int io_c,
                           output int re_c, output int we_c, output int busy_c,
                           output logic got_err, output bit other_ack, output bit bad_bus,
                           output bit timeout);
    int n;
    lat = 0; rom_c = 0; ram_c = 0; io_c = 0; re_c = 0; we_c = 0; busy_c = 0;
    got_err = 1'b0; other_ack = 0; bad_bus = 0; timeout = 1;
    @(negedge clk);
    mem_rdata = bus;
    if (who) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else     begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (who) begin addr1 = $urandom; wdata1 = $urandom; we1 = ~we; end
        else     begin addr0 = $urandom; wdata0 = $urandom; we0 = ~we; end
      end
      if (!rom_nce) rom_c++;
      if (!ram_nce) ram_c++;
      if (!io_nce) io_c++;
      if (mem_re) re_c++;
      if (mem_we) we_c++;
      if (busy) busy_c++;
      if ((mem_re || mem_we) && (mem_addr !== addr || (we && mem_wdata !== wdata))) bad_bus = 1;
      if (who ? ack0 : ack1) other_ack = 1;
      if (who ? ack1 : ack0) begin
        lat = n;
        got_err = who ? err1 : err0;
        timeout = 0;
        break;
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b%b required 00", ack0, ack1); end
    n_cmp++; if (err0 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b%b required 00", err0, err1); end
    n_cmp++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h %h required 0", rdata0, rdata1); end
    n_cmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_mem_bus: got %h %h required 0", mem_addr, mem_wdata); end
    n_cmp++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b%b required 00", mem_re, mem_we); end
    n_cmp++; if ({rom_nce, ram_nce, io_nce} !== 3'b111) begin n_fail++; $display("[TB] FAIL reset_nce: got %b%b%b required 111", rom_nce, ram_nce, io_nce); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_rom_read();
    int lat, rc, mc, ic, re, wc, bc; logic e; bit oa, bb, to;
    drive_txn(0, 1'b0, 32'h0000_0004, 32'h0, 32'h2010_0005, lat, rc, mc, ic, re, wc, bc, e, oa, bb, to);
    exp_rd[0] = 32'h2010_0005;
    n_cmp++; if (to || lat != ROM_W + 2) begin n_fail++; $display("[TB] FAIL rom_latency: got %0d (timeout %0d) required %0d", lat, to, ROM_W + 2); end
    n_cmp++; if (rc != ROM_W + 1 || mc != 0 || ic != 0) begin n_fail++; $display("[TB] FAIL rom_nce: got rom %0d ram %0d io %0d required %0d 0 0", rc, mc, ic, ROM_W + 1); end
    n_cmp++; if (re != ROM_W + 1 || wc != 0) begin n_fail++; $display("[TB] FAIL rom_strobe: got re %0d we %0d required %0d 0", re, wc, ROM_W + 1); end
    n_cmp++; if (rdata0 !== exp_rd[0] || e !== 1'b0) begin n_fail++; $display("[TB] FAIL rom_rdata: got %h err %b required %h err 0", rdata0, e, exp_rd[0]); end
    n_cmp++; if (bb || oa) begin n_fail++; $display("[TB] FAIL rom_bus: got bad_bus %0d other_ack %0d required 0 0", bb, oa); end
  endtask

  task automatic test_ram_write();
    int lat, rc, mc, ic, re, wc, bc; logic e; bit oa, bb, to;
    drive_txn(0, 1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 32'h5555_AAAA, lat, rc, mc, ic, re, wc, bc, e, oa, bb, to);
    n_cmp++; if (to || lat != RAM_W + 2) begin n_fail++; $display("[TB] FAIL ram_latency: got %0d required %0d", lat, RAM_W + 2); end
    n_cmp++; if (mc != RAM_W + 1 || wc != RAM_W + 1 || re != 0) begin n_fail++; $display("[TB] FAIL ram_strobe: got nce %0d we %0d re %0d required %0d %0d 0", mc, wc, re, RAM_W + 1, RAM_W + 1); end
    n_cmp++; if (bb) begin n_fail++; $display("[TB] FAIL ram_wdata: got bad bus address/data required %h", 32'hDEAD_BEEF); end
    n_cmp++; if (rdata0 !== exp_rd[0] || e !== 1'b0) begin n_fail++; $display("[TB] FAIL ram_rdata_kept: got %h err %b required %h err 0", rdata0, e, exp_rd[0]); end
  endtask

  task automatic test_errors();
    int lat, rc, mc, ic, re, wc, bc; logic e; bit oa, bb, to;
    drive_txn(0, 1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0, lat, rc, mc, ic, re, wc, bc, e, oa, bb, to);
    n_cmp++; if (to || lat != 1 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL rom_write_err: got lat %0d err %b required 1 1", lat, e); end
    n_cmp++; if (rc + mc + ic + re + wc != 0) begin n_fail++; $display("[TB] FAIL rom_write_quiet: got %0d active cycles required 0", rc + mc + ic + re + wc); end
    drive_txn(1, 1'b0, 32'h0000_6000, 32'h0, 32'hFFFF_FFFF, lat, rc, mc, ic, re, wc, bc, e, oa, bb, to);
    exp_rd[1] = 32'd0;
    n_cmp++; if (to || lat != 1 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL region3_err: got lat %0d err %b required 1 1", lat, e); end
    n_cmp++; if (rc + mc + ic + re + wc != 0 || rdata1 !== 32'd0) begin n_fail++; $display("[TB] FAIL region3_quiet: got %0d active rdata %h required 0 0", rc + mc + ic + re + wc, rdata1); end
  endtask

  task automatic test_round_robin();
    int order[$];
    bit drop0, drop1, both;
    int n;
    do_reset();
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    we0 = 0; addr0 = 32'h0000_2000; we1 = 0; addr1 = 32'h0000_2040;
    req0 = 1; req1 = 1;
    drop0 = 0; drop1 = 0; both = 0; n = 0;
    while (order.size() < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (ack0 && ack1) both = 1;
      if (ack0) begin order.push_back(0); req0 = 0; drop0 = 1; end
      else if (drop0) begin req0 = 1; drop0 = 0; end
      if (ack1) begin order.push_back(1); req1 = 0; drop1 = 1; end
      else if (drop1) begin req1 = 1; drop1 = 0; end
    end
    req0 = 0; req1 = 0;
    repeat (8) @(negedge clk);
    exp_rd[0] = 32'h1234_5678;
    exp_rd[1] = 32'h1234_5678;
    n_cmp++; if (order.size() != 6 || both) begin n_fail++; $display("[TB] FAIL rr_count: got %0d acks (simultaneous %0d) required 6 0", order.size(), both); end
    for (int i = 0; i < order.size(); i++) begin
      n_cmp++; if (order[i] != i % 2) begin n_fail++; $display("[TB] FAIL rr_order[%0d]: got %0d required %0d", i, order[i], i % 2); end
    end
    n_cmp++; if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin n_fail++; $display("[TB] FAIL rr_rdata: got %h %h required %h", rdata0, rdata1, exp_rd[0]); end
  endtask

  task automatic test_io_and_reset();
    int lat, rc, mc, ic, re, wc, bc; logic e; bit oa, bb, to;
    drive_txn(1, 1'b1, 32'h0000_4000, 32'h0BAD_F00D, 32'h0, lat, rc, mc, ic, re, wc, bc, e, oa, bb, to);
    n_cmp++; if (to || ic != IO_W + 1 || bc != IO_W + 2 || lat != IO_W + 2) begin n_fail++; $display("[TB] FAIL io_write: got nce %0d busy %0d lat %0d required %0d %0d %0d", ic, bc, lat, IO_W + 1, IO_W + 2, IO_W + 2); end
    n_cmp++; if (wc != IO_W + 1 || e !== 1'b0 || bb) begin n_fail++; $display("[TB] FAIL io_strobe: got we %0d err %b bad %0d required %0d 0 0", wc, e, bb, IO_W + 1); end
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 32'h0000_4000; wdata1 = 32'h0000_0077;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (io_nce !== 1'b0 || mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL io_second_cycle: got nce %b we %b required 0 1", io_nce, mem_we); end
    rst = 1; req1 = 0;
    @(negedge clk);
    rst = 0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    n_cmp++; if (io_nce !== 1'b1 || mem_we !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL io_abort: got nce %b we %b ack1 %b busy %b required 1 0 0 0", io_nce, mem_we, ack1, busy); end
    repeat (4) @(negedge clk);
    n_cmp++; if (ack1 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL io_after_abort: got ack1 %b busy %b required 0 0", ack1, busy); end
  endtask

  task automatic test_dropped_req();
    bit saw_ack1, bad, got;
    int n;
    saw_ack1 = 0; bad = 0; got = 0; n = 0;
    @(negedge clk);
    mem_rdata = 32'hCAFE_F00D;
    req0 = 1; we0 = 0; addr0 = 32'h0000_2004;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin req1 = 1; we1 = 0; addr1 = 32'h0000_2100; end
      if (n == 2) req1 = 0;
      if (ack1) saw_ack1 = 1;
      if ((mem_re || mem_we) && mem_addr == 32'h0000_2100) bad = 1;
      if (ack0) begin req0 = 0; got = 1; break; end
    end
    repeat (6) begin
      @(negedge clk);
      if (ack1) saw_ack1 = 1;
      if (mem_re || mem_we || busy) bad = 1;
    end
    exp_rd[0] = 32'hCAFE_F00D;
    n_cmp++; if (!got || rdata0 !== exp_rd[0]) begin n_fail++; $display("[TB] FAIL drop_cpu_read: got ack %0d rdata %h required 1 %h", got, rdata0, exp_rd[0]); end
    n_cmp++; if (saw_ack1 || bad) begin n_fail++; $display("[TB] FAIL drop_dma_served: got ack1 %0d activity %0d required 0 0", saw_ack1, bad); end
    n_cmp++; if (rdata1 !== exp_rd[1]) begin n_fail++; $display("[TB] FAIL drop_rdata1: got %h required %h", rdata1, exp_rd[1]); end
  endtask

  task automatic test_random();
    int lat, rc, mc, ic, re, wc, bc; logic e; bit oa, bb, to;
    bit who, legal; logic we; logic [31:0] addr, wd, bus;
    int w, r, act;
    for (int k = 0; k < 40; k++) begin
      who = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      addr = $urandom;
      addr[15:13] = 3'($urandom_range(0, 7));
      wd = $urandom; bus = $urandom;
      drive_txn(who, we, addr, wd, bus, lat, rc, mc, ic, re, wc, bc, e, oa, bb, to);
      legal = is_legal(we, addr);
      w = region_wait(addr);
      r = addr[15:13];
      act = legal ? w + 1 : 0;
      if (!we) exp_rd[who] = legal ? bus : 32'd0;
      n_cmp++; if (to || lat != (legal ? w + 2 : 1) || e !== !legal || oa) begin n_fail++; $display("[TB] FAIL rand_ack[%0d]: got lat %0d err %b other %0d required %0d %b 0", k, lat, e, oa, legal ? w + 2 : 1, !legal); end
      n_cmp++; if (rc != (r == 0 ? act : 0) || mc != (r == 1 ? act : 0) || ic != (r == 2 ? act : 0)) begin n_fail++; $display("[TB] FAIL rand_nce[%0d]: got %0d %0d %0d region %0d required %0d", k, rc, mc, ic, r, act); end
      n_cmp++; if (re != (we ? 0 : act) || wc != (we ? act : 0) || bb || bc != lat) begin n_fail++; $display("[TB] FAIL rand_strobe[%0d]: got re %0d we %0d busy %0d bad %0d required act %0d", k, re, wc, bc, bb, act); end
      n_cmp++; if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin n_fail++; $display("[TB] FAIL rand_rdata[%0d]: got %h %h required %h %h", k, rdata0, rdata1, exp_rd[0], exp_rd[1]); end
    end
  endtask

  initial begin
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    test_reset();
    test_rom_read();
    test_ram_write();
    test_errors();
    test_round_robin();
    test_io_and_reset();
    test_dropped_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
